// File: rtl/vga_sync_gen.sv
// VGA timing generator and output stage: free-running h/v counters, sync decode,
// and one register stage that aligns colour and syncs on the same clock edge.
module vga_sync_gen #(
  parameter int HVID  = 640,
  parameter int HFP   = 16,
  parameter int HSYNC = 96,
  parameter int HBP   = 48,
  parameter int VVID  = 480,
  parameter int VFP   = 10,
  parameter int VSYNC = 2,
  parameter int VBP   = 33
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] horizontal_num,
  output logic [9:0] vertical_num,
  output logic       video_on,
  output logic       frame_end,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int HTOT = HVID + HFP + HSYNC + HBP;
  localparam int VTOT = VVID + VFP + VSYNC + VBP;

  // Totals must not exceed 1024 so every boundary fits the 10-bit counters.
  localparam logic [9:0] H_LAST   = 10'(HTOT - 1);
  localparam logic [9:0] V_LAST   = 10'(VTOT - 1);
  localparam logic [9:0] H_VID    = 10'(HVID);
  localparam logic [9:0] V_VID    = 10'(VVID);
  localparam logic [9:0] HS_BEG   = 10'(HVID + HFP);
  localparam logic [9:0] HS_END   = 10'(HVID + HFP + HSYNC);
  localparam logic [9:0] VS_BEG   = 10'(VVID + VFP);
  localparam logic [9:0] VS_END   = 10'(VVID + VFP + VSYNC);

  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;
  logic       h_last_s;
  logic       v_last_s;
  logic       hs_n_s;
  logic       vs_n_s;
  logic [3:0] pix_r_s;
  logic [3:0] pix_g_s;
  logic [3:0] pix_b_s;

  // Boundary decode, sync windows and blanking, all from the current counters.
  always_comb begin
    h_last_s = (h_cnt_r == H_LAST);
    v_last_s = (v_cnt_r == V_LAST);
    hs_n_s   = !((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END));
    vs_n_s   = !((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END));
    if (video_on) begin
      pix_r_s = red_in;
      pix_g_s = green_in;
      pix_b_s = blue_in;
    end else begin
      pix_r_s = 4'h0;
      pix_g_s = 4'h0;
      pix_b_s = 4'h0;
    end
  end

  // Pixel and line counters; both wrap on the same edge at end of frame.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_last_s) begin
      h_cnt_r <= 10'd0;
      if (v_last_s) begin
        v_cnt_r <= 10'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Pin register: syncs and blanked colour share one stage so they stay aligned.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
    end else begin
      vga_hs <= hs_n_s;
      vga_vs <= vs_n_s;
      vga_r  <= pix_r_s;
      vga_g  <= pix_g_s;
      vga_b  <= pix_b_s;
    end
  end

  assign horizontal_num = h_cnt_r;
  assign vertical_num   = v_cnt_r;
  assign video_on       = (h_cnt_r < H_VID) && (v_cnt_r < V_VID);
  assign frame_end      = h_last_s && v_last_s;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing, a short-frame variant (full 800-pixel lines,
// 10 lines) and a tiny-parameter variant, each checked cycle by cycle.
module tb_vga_sync_gen;

  logic clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  logic rst_a_n = 1'b1, rst_b_n = 1'b1, rst_c_n = 1'b1;

  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
  logic       a_von, a_fe, a_hs, a_vs, b_von, b_fe, b_hs, b_vs, c_von, c_fe, c_hs, c_vs;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  logic [3:0] a_red;

  // Vertical bar: red only in the first 160 columns.
  assign a_red = (a_h < 10'd160) ? 4'hF : 4'h0;

  vga_sync_gen dut_a (
    .clk_25(clk_25), .rst_n(rst_a_n),
    .red_in(a_red), .green_in(4'h0), .blue_in(4'h0),
    .horizontal_num(a_h), .vertical_num(a_v), .video_on(a_von), .frame_end(a_fe),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
  );

  vga_sync_gen #(.HVID(640), .HFP(16), .HSYNC(96), .HBP(48),
                 .VVID(4), .VFP(2), .VSYNC(2), .VBP(2)) dut_b (
    .clk_25(clk_25), .rst_n(rst_b_n),
    .red_in(4'hF), .green_in(4'hF), .blue_in(4'hF),
    .horizontal_num(b_h), .vertical_num(b_v), .video_on(b_von), .frame_end(b_fe),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
  );

  vga_sync_gen #(.HVID(4), .HFP(1), .HSYNC(2), .HBP(1),
                 .VVID(2), .VFP(1), .VSYNC(1), .VBP(1)) dut_c (
    .clk_25(clk_25), .rst_n(rst_c_n),
    .red_in(4'hF), .green_in(4'hF), .blue_in(4'hF),
    .horizontal_num(c_h), .vertical_num(c_v), .video_on(c_von), .frame_end(c_fe),
    .vga_hs(c_hs), .vga_vs(c_vs), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ca = 0, cb = 0, cc = 0;
  bit b_hold = 1'b0, phase2 = 1'b0;
  int a_hs_cnt = 0, a_hs_first = 0, a_bar_cnt = 0, a_bar_first = 0;
  int b_vs_cnt = 0, b_vs_first = 0, b_fe_cnt = 0, b_fe_at = 0;
  int b_hs_cnt2 = 0, b_hs_first2 = 0, c_fe_cnt = 0, c_fe_last = 0;

  task automatic check_val(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, observed, expected);
  endtask

  task automatic check_rst(input string tag, input int h, input int v, input int von,
                           input int fe, input int hs, input int vs,
                           input int r, input int g, input int b);
    check_val({tag, "_h"}, h, 0);    check_val({tag, "_v"}, v, 0);
    check_val({tag, "_von"}, von, 1); check_val({tag, "_fe"}, fe, 0);
    check_val({tag, "_hs"}, hs, 1);  check_val({tag, "_vs"}, vs, 1);
    check_val({tag, "_r"}, r, 0);    check_val({tag, "_g"}, g, 0);
    check_val({tag, "_b"}, b, 0);
  endtask

  function automatic int in_win(input int x, input int lo, input int hi);
    return (x >= lo && x < hi) ? 1 : 0;
  endfunction

  // One clock: advance cycle counts, compare every DUT against its timing model.
  task automatic step();
    int h, v, ph, pv, pix;
    @(posedge clk_25); #1;
    ca++; cc++;
    if (!b_hold) cb++;

    h = ca % 800; v = (ca / 800) % 525; ph = (ca - 1) % 800; pv = ((ca - 1) / 800) % 525;
    check_val("a_h", a_h, h);  check_val("a_v", a_v, v);
    check_val("a_von", a_von, (h < 640 && v < 480) ? 1 : 0);
    check_val("a_fe", a_fe, (h == 799 && v == 524) ? 1 : 0);
    check_val("a_hs", a_hs, 1 - in_win(ph, 656, 752));
    check_val("a_vs", a_vs, 1 - in_win(pv, 490, 492));
    check_val("a_r", a_r, (ph < 160 && pv < 480) ? 15 : 0);
    check_val("a_g", a_g, 0);
    if (ca <= 800) begin
      if (a_hs == 1'b0) begin a_hs_cnt++; if (a_hs_first == 0) a_hs_first = ca; end
      if (a_r == 4'hF)  begin a_bar_cnt++; if (a_bar_first == 0) a_bar_first = ca; end
    end

    if (b_hold) begin
      check_rst("b_hold", b_h, b_v, b_von, b_fe, b_hs, b_vs, b_r, b_g, b_b);
    end else begin
      h = cb % 800; v = (cb / 800) % 10; ph = (cb - 1) % 800; pv = ((cb - 1) / 800) % 10;
      pix = (ph < 640 && pv < 4) ? 15 : 0;
      check_val("b_h", b_h, h);  check_val("b_v", b_v, v);
      check_val("b_von", b_von, (h < 640 && v < 4) ? 1 : 0);
      check_val("b_fe", b_fe, (h == 799 && v == 9) ? 1 : 0);
      check_val("b_hs", b_hs, 1 - in_win(ph, 656, 752));
      check_val("b_vs", b_vs, 1 - in_win(pv, 6, 8));
      check_val("b_r", b_r, pix); check_val("b_g", b_g, pix); check_val("b_b", b_b, pix);
      if (!phase2) begin
        if (cb <= 8000 && b_vs == 1'b0) begin b_vs_cnt++; if (b_vs_first == 0) b_vs_first = cb; end
        if (b_fe) begin b_fe_cnt++; b_fe_at = cb; end
      end else if (cb <= 800 && b_hs == 1'b0) begin
        b_hs_cnt2++; if (b_hs_first2 == 0) b_hs_first2 = cb;
      end
    end

    h = cc % 8; v = (cc / 8) % 5; ph = (cc - 1) % 8; pv = ((cc - 1) / 8) % 5;
    pix = (ph < 4 && pv < 2) ? 15 : 0;
    check_val("c_h", c_h, h);  check_val("c_v", c_v, v);
    check_val("c_von", c_von, (h < 4 && v < 2) ? 1 : 0);
    check_val("c_fe", c_fe, (h == 7 && v == 4) ? 1 : 0);
    check_val("c_hs", c_hs, 1 - in_win(ph, 5, 7));
    check_val("c_vs", c_vs, (pv == 3) ? 0 : 1);
    check_val("c_r", c_r, pix); check_val("c_b", c_b, pix);
    if (c_fe) begin
      c_fe_cnt++;
      if (c_fe_last != 0) check_val("c_fe_gap", cc - c_fe_last, 40);
      c_fe_last = cc;
    end
  endtask

  initial begin
    #1;
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    #2;
    check_rst("a_rst", a_h, a_v, a_von, a_fe, a_hs, a_vs, a_r, a_g, a_b);
    check_rst("b_rst", b_h, b_v, b_von, b_fe, b_hs, b_vs, b_r, b_g, b_b);
    check_rst("c_rst", c_h, c_v, c_von, c_fe, c_hs, c_vs, c_r, c_g, c_b);
    repeat (2) @(posedge clk_25);
    @(negedge clk_25);
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;

    // Run up to h=700, v=7 of the short frame's second pass (inside vsync and hsync).
    repeat (14300) step();

    check_val("a_hs_first", a_hs_first, 657);
    check_val("a_hs_width", a_hs_cnt, 96);
    check_val("a_bar_first", a_bar_first, 1);
    check_val("a_bar_width", a_bar_cnt, 160);
    check_val("b_vs_first", b_vs_first, 4801);
    check_val("b_vs_width", b_vs_cnt, 1600);
    check_val("b_fe_count", b_fe_cnt, 1);
    check_val("b_fe_cycle", b_fe_at, 7999);
    check_val("c_fe_count", c_fe_cnt, 357);

    // Asynchronous reset in the middle of both syncs, no clock edge in between.
    check_val("b_pre_hs", b_hs, 0);
    check_val("b_pre_vs", b_vs, 0);
    rst_b_n = 1'b0;
    #1;
    check_rst("b_midrst", b_h, b_v, b_von, b_fe, b_hs, b_vs, b_r, b_g, b_b);
    b_hold = 1'b1;
    repeat (2) step();
    @(negedge clk_25);
    rst_b_n = 1'b1;
    b_hold  = 1'b0;
    phase2  = 1'b1;
    cb      = 0;
    repeat (800) step();
    check_val("b_rel_hs_first", b_hs_first2, 657);
    check_val("b_rel_hs_width", b_hs_cnt2, 96);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
